param_deserializer: RTL and testbench
=====================================

// Module: param_deserializer
// PURPOSE
//  Serial-to-parallel front end for the parameterised word datapath. Collects N
//  serial bits into one N-bit word and presents it on data_out with valid/ready
//  handshake. Sits directly upstream of the width-parameterised pass-through
//  stage: data_out drives that stage's data_in, and N matches its input width.
// PARAMETERS
//  N          5   word width in bits; legal N >= 2
//  MSB_FIRST  1   1: first received bit lands in data_out[N-1]; 0: in data_out[0]
// PORTS
//  clk         input   1    single clock, all state on rising edge
//  rst         input   1    synchronous reset, active-high
//  ser_in      input   1    serial data bit
//  ser_valid   input   1    ser_in valid this cycle
//  ser_ready   output  1    block accepts ser_in this cycle
//  data_out    output  N    assembled word (registered)
//  data_valid  output  1    data_out holds an unconsumed word
//  data_ready  input   1    downstream consumes data_out this cycle
//  bit_count   output  CW   bits of partial word held; CW = $clog2(N)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): shift reg=0, bit_count=0, data_out=0,
//   data_valid=0; partial word discarded. ser_ready is 1 in the cycle after reset.
//  Handshakes: bit accepted on edge with ser_valid&&ser_ready; word consumed on
//   edge with data_valid&&data_ready. ser_valid gaps allowed; no timeout.
//  Control (counter-based FSM): FILL (bit_count 0..N-2) and LAST (bit_count=N-1).
//   FILL + accept: shift bit in, bit_count+1; LAST once bit_count reaches N-1.
//   LAST + accept: word completes; bit_count->0, back to FILL.
//  Shift order: MSB_FIRST=1 -> sh <= {sh[N-2:0], ser_in}; word = {sh[N-2:0], ser_in}.
//   MSB_FIRST=0 -> sh <= {ser_in, sh[N-1:1]}; word = {ser_in, sh[N-1:1]}.
//  Output slot (one entry): on word completion data_out<=word, data_valid<=1.
//   Latency: data_valid high the cycle after the Nth bit is accepted.
//  ser_ready = !(bit_count==N-1 && data_valid && !data_ready). Only the final bit
//   is ever stalled; bits 1..N-1 of the next word are always accepted while a
//   word waits in the slot.
//  Stability: while data_valid && !data_ready, data_out and data_valid hold.
//  Simultaneous consume + complete: data_valid stays 1, data_out takes new word
//   on same edge (no bubble, no loss).
//  Consume without complete: data_valid<=0; data_out retains old value.
//  ser_valid=0 or ser_ready=0: shift reg and bit_count unchanged.
//  rst has priority over every handshake on the same edge.
//  Throughput: one word per N cycles sustained with data_ready tied high.
// TESTING
//  T1 N=5 MSB_FIRST=1, data_ready=1, bits 1,0,1,1,0 back-to-back -> data_out=5'b10110,
//     data_valid=1 exactly one cycle after 5th bit, for one cycle.
//  T2 MSB_FIRST=0, same bits -> data_out=5'b01101.
//  T3 data_ready=0 after word 5'b10110; feed 1,1,1,1 -> all accepted, bit_count=4;
//     5th bit 1 -> ser_ready=0, data_out stays 5'b10110; raise data_ready -> bit
//     accepted same edge, next cycle data_out=5'b11111, data_valid=1.
//  T4 Random ser_valid gaps (50%), 20 words, random data_ready -> scoreboard sees
//     every word in order, none dropped or duplicated.
//  T5 rst after 3 bits (1,1,1) of a word -> bit_count=0, data_valid=0; then
//     0,0,0,0,1 -> data_out=5'b00001 (no leftover bits).
//  T6 Word held with data_valid=1; rst asserted -> data_valid=0, data_out=0 next
//     cycle regardless of data_ready.

Source files
------------

// File: rtl/param_deserializer.sv
// Serial-to-parallel front end: gathers N serial bits into one registered N-bit word
// and hands it downstream through a one-entry valid/ready output slot.
module param_deserializer #(
  parameter int N         = 5,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ser_in,
  input  logic          ser_valid,
  output logic          ser_ready,
  output logic [N-1:0]  data_out,
  output logic          data_valid,
  input  logic          data_ready,
  output logic [CW-1:0] bit_count
);

  typedef enum logic {FILL, LAST} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sh, sh_nxt, dout_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dv_nxt, accept, consume, complete;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[N-2:0], b};
    else           return {b, cur[N-1:1]};
  endfunction

  // Only the word-completing bit can stall, and only while the slot is still occupied.
  assign ser_ready = !(state == LAST && data_valid && !data_ready);
  assign bit_count = cnt;
  assign accept    = ser_valid && ser_ready;
  assign consume   = data_valid && data_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    complete  = 1'b0;
    if (accept) begin
      sh_nxt = shift_in(sh, ser_in);
      case (state)
        FILL: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(N - 2)) state_nxt = LAST;
        end
        LAST: begin
          cnt_nxt   = '0;
          state_nxt = FILL;
          complete  = 1'b1;
        end
        default: state_nxt = FILL;
      endcase
    end
    dout_nxt = complete ? sh_nxt : data_out;
    dv_nxt   = complete ? 1'b1 : (consume ? 1'b0 : data_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      sh         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh         <= sh_nxt;
      data_out   <= dout_nxt;
      data_valid <= dv_nxt;
    end
  end

endmodule

// File: tb/tb_param_deserializer.sv
// Directed table plus random scoreboard bench for param_deserializer (N=5),
// with one MSB-first and one LSB-first instance sharing the same stimulus.
module tb_param_deserializer;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst, ser_in, ser_valid, data_ready;
  logic       ser_ready, data_valid, ser_ready_l, data_valid_l;
  logic [4:0] data_out, data_out_l;
  logic [2:0] bit_count, bit_count_l;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .bit_count(bit_count)
  );

  param_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready_l), .data_out(data_out_l), .data_valid(data_valid_l),
    .data_ready(data_ready), .bit_count(bit_count_l)
  );

  typedef struct {
    logic       rst, sin, sv, dr;  // inputs for the cycle
    logic       sr;                // expected ser_ready during the cycle
    logic       dv;                // expected after the edge
    logic [4:0] dout;
    logic [2:0] bc;
    logic       chk_l;             // also check the LSB-first instance
    logic [4:0] dout_l;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r, int s, int v, int d, int sr, int dv,
                              int dout, int bc, int cl = 0, int dl = 0);
    vec_t x;
    x.rst = r[0]; x.sin = s[0]; x.sv = v[0]; x.dr = d[0]; x.sr = sr[0];
    x.dv = dv[0]; x.dout = dout[4:0]; x.bc = bc[2:0];
    x.chk_l = cl[0]; x.dout_l = dl[4:0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [4:0] words[20];
  int         w_in, k_in, w_out, cyc;

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // rst sin sv dr | sr dv dout bc
    vecs.push_back(mk(1,0,0,1, 1,0,5'b00000,0));
    // bits 1,0,1,1,0 back to back, downstream always ready
    vecs.push_back(mk(0,1,1,1, 1,0,5'b00000,1));
    vecs.push_back(mk(0,0,1,1, 1,0,5'b00000,2));
    vecs.push_back(mk(0,1,1,1, 1,0,5'b00000,3));
    vecs.push_back(mk(0,1,1,1, 1,0,5'b00000,4));
    vecs.push_back(mk(0,0,1,1, 1,1,5'b10110,0, 1,5'b01101));
    vecs.push_back(mk(0,0,0,1, 1,0,5'b10110,0));
    // same word with the slot blocked, then 1,1,1,1 all accepted
    vecs.push_back(mk(0,1,1,0, 1,0,5'b10110,1));
    vecs.push_back(mk(0,0,1,0, 1,0,5'b10110,2));
    vecs.push_back(mk(0,1,1,0, 1,0,5'b10110,3));
    vecs.push_back(mk(0,1,1,0, 1,0,5'b10110,4));
    vecs.push_back(mk(0,0,1,0, 1,1,5'b10110,0));
    vecs.push_back(mk(0,1,1,0, 1,1,5'b10110,1));
    vecs.push_back(mk(0,1,1,0, 1,1,5'b10110,2));
    vecs.push_back(mk(0,1,1,0, 1,1,5'b10110,3));
    vecs.push_back(mk(0,1,1,0, 1,1,5'b10110,4));
    // last bit stalls, then consume and complete on the same edge
    vecs.push_back(mk(0,1,1,0, 0,1,5'b10110,4));
    vecs.push_back(mk(0,1,1,1, 1,1,5'b11111,0));
    vecs.push_back(mk(0,0,0,1, 1,0,5'b11111,0));
    // three bits then reset (with a valid bit offered on the reset edge)
    vecs.push_back(mk(0,1,1,1, 1,0,5'b11111,1));
    vecs.push_back(mk(0,1,1,1, 1,0,5'b11111,2));
    vecs.push_back(mk(0,1,1,1, 1,0,5'b11111,3));
    vecs.push_back(mk(1,1,1,1, 1,0,5'b00000,0));
    vecs.push_back(mk(0,0,1,1, 1,0,5'b00000,1));
    vecs.push_back(mk(0,0,1,1, 1,0,5'b00000,2));
    vecs.push_back(mk(0,0,1,1, 1,0,5'b00000,3));
    vecs.push_back(mk(0,0,1,1, 1,0,5'b00000,4));
    vecs.push_back(mk(0,1,1,0, 1,1,5'b00001,0, 1,5'b10000));
    // held word cleared by reset even though nobody consumed it
    vecs.push_back(mk(0,0,0,0, 1,1,5'b00001,0));
    vecs.push_back(mk(1,0,0,0, 1,0,5'b00000,0));
    vecs.push_back(mk(0,0,0,0, 1,0,5'b00000,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ser_in = vecs[i].sin;
      ser_valid = vecs[i].sv; data_ready = vecs[i].dr;
      #1;
      chk($sformatf("v%0d ser_ready", i), 32'(ser_ready), 32'(vecs[i].sr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d data_valid", i), 32'(data_valid), 32'(vecs[i].dv));
      chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
      chk($sformatf("v%0d bit_count", i), 32'(bit_count), 32'(vecs[i].bc));
      if (vecs[i].chk_l)
        chk($sformatf("v%0d data_out_lsb", i), 32'(data_out_l), 32'(vecs[i].dout_l));
    end

    // Random gaps and back-pressure; every word must come out once, in order.
    foreach (words[j]) words[j] = 5'($urandom_range(0, 31));
    w_in = 0; k_in = 0; w_out = 0; cyc = 0;
    rst = 1'b0;
    while (w_out < 20 && cyc < 3000) begin
      ser_valid  = (w_in < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      ser_in     = (w_in < 20) ? words[w_in][N-1-k_in] : 1'b0;
      data_ready = 1'($urandom_range(0, 1));
      #1;
      if (data_valid && data_ready) begin
        chk($sformatf("rand word %0d", w_out), 32'(data_out), 32'(words[w_out]));
        w_out++;
      end
      if (ser_valid && ser_ready) begin
        k_in++;
        if (k_in == N) begin
          k_in = 0;
          w_in++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand words received", 32'(w_out), 32'd20);
    ser_valid = 1'b0; data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rand no extra word", 32'(data_valid), 32'd0);
    chk("rand bit_count idle", 32'(bit_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
